// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 memory responder: default storage depth,
// word-address width, responder FSM states and the port grant encoding.
package mips32_pkg;

   // Default storage size in 32-bit words and the matching word-address width.
   localparam int MEM_DEPTH = 1024;
   localparam int MEM_AW    = $clog2(MEM_DEPTH);
   localparam int DATA_W    = 32;

   // Responder transaction phases.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   // Which requester owns the current transaction.
   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_DM = 1'b1
   } grant_e;

   // Round-robin pick between the two requesters. A lone requester always
   // wins; on a tie the data port wins unless it also won the previous grant.
   function automatic grant_e arbitrate(input logic   if_valid,
                                        input logic   dm_valid,
                                        input grant_e last_grant);
      grant_e pick;
      if (if_valid && dm_valid) begin
         pick = (last_grant == GNT_DM) ? GNT_IF : GNT_DM;
      end else if (dm_valid) begin
         pick = GNT_DM;
      end else begin
         pick = GNT_IF;
      end
      return pick;
   endfunction

endpackage

// File: rtl/mips32_mem_array.sv
// Synchronous single-port word storage: one read or one write per cycle.
// Read data is registered and holds its value while the port is idle.
// Contents are never reset.
module mips32_mem_array
   import mips32_pkg::*;
#(
   parameter int DEPTH = MEM_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Single port: an enabled cycle either writes the word or registers a read.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            mem[addr_i] <= wdata_i;
         end else begin
            rdata_q <= mem[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mips32_mem_responder.sv
// Memory responder shared by the MIPS32 instruction-fetch (IF) and data (DM)
// ports. One transaction at a time walks IDLE -> ACCESS -> RESP:
//   - the request is accepted in IDLE; address is captured and a store is
//     written to the array on that same edge,
//   - ACCESS registers the read data out of the array,
//   - RESP presents the response on the granted port only, holding it until
//     that port's rsp_ready is seen.
// Handshake rule on every port: a transfer happens on a rising clk1 edge where
// valid && ready are both high; valid and payload stay stable until then.
// Optional build macro MEM_RANGE_CHECK_EN: addresses >= DEPTH answer with
// rsp_err=1 and zero data and never write. Without it the address wraps onto
// its low log2(DEPTH) bits and rsp_err is tied low.
module mips32_mem_responder
   import mips32_pkg::*;
#(
   parameter int DEPTH = MEM_DEPTH
) (
   input  logic              clk1,
   input  logic              rst,
   // instruction fetch port
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [31:0]       if_req_addr,
   output logic              if_rsp_valid,
   input  logic              if_rsp_ready,
   output logic [DATA_W-1:0] if_rsp_data,
   // data port
   input  logic              dm_req_valid,
   output logic              dm_req_ready,
   input  logic              dm_req_we,
   input  logic [31:0]       dm_req_addr,
   input  logic [DATA_W-1:0] dm_req_wdata,
   output logic              dm_rsp_valid,
   input  logic              dm_rsp_ready,
   output logic [DATA_W-1:0] dm_rsp_data,
   output logic              rsp_err,
   // observation of the transaction phase
   output state_e            dbg_state_o
);

   localparam int AW = $clog2(DEPTH);

   // Registered FSM state and per-transaction context.
   state_e          state_q;
   grant_e          grant_q;
   grant_e          last_grant_q;
   logic [AW-1:0]   addr_q;
   logic            we_q;
   logic            err_q;
   logic            rsp_valid_q;

   // Request-side selection for the current IDLE cycle.
   grant_e          gnt_d;
   logic            accept_d;
   logic [31:0]     sel_addr_d;
   logic [AW-1:0]   sel_idx_d;
   logic            sel_we_d;
   logic            sel_err_d;
   logic            rsp_take_d;

   // Array port controls.
   logic            mem_en;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] rsp_data_d;

   // Arbitration and request decode; nothing is accepted while reset is high.
   always_comb begin
      gnt_d      = arbitrate(if_req_valid, dm_req_valid, last_grant_q);
      accept_d   = !rst && (state_q == ST_IDLE) && (if_req_valid || dm_req_valid);
      sel_addr_d = (gnt_d == GNT_DM) ? dm_req_addr : if_req_addr;
      sel_idx_d  = sel_addr_d[AW-1:0];
      sel_we_d   = (gnt_d == GNT_DM) && dm_req_we;
`ifdef MEM_RANGE_CHECK_EN
      sel_err_d  = (sel_addr_d >= 32'(DEPTH));
`else
      sel_err_d  = 1'b0;
`endif
   end

`ifndef MEM_RANGE_CHECK_EN
   // Upper address bits are dropped on purpose: the address wraps.
   logic unused_addr_hi;
   assign unused_addr_hi = ^sel_addr_d[31:AW];
`endif

   assign if_req_ready = accept_d && (gnt_d == GNT_IF);
   assign dm_req_ready = accept_d && (gnt_d == GNT_DM);

   // The granted port's response is consumed when its ready is high.
   always_comb begin
      rsp_take_d = (grant_q == GNT_DM) ? dm_rsp_ready : if_rsp_ready;
   end

   // Array sharing: the store lands on the acceptance edge, the load read
   // happens during ACCESS. Out-of-range accesses never touch the array.
   always_comb begin
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = addr_q;
      if (state_q == ST_IDLE) begin
         mem_en   = accept_d && sel_we_d && !sel_err_d;
         mem_we   = 1'b1;
         mem_addr = sel_idx_d;
      end else if (state_q == ST_ACCESS) begin
         mem_en   = !we_q && !err_q;
         mem_we   = 1'b0;
         mem_addr = addr_q;
      end
   end

   mips32_mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk_i   (clk1),
      .en_i    (mem_en),
      .we_i    (mem_we),
      .addr_i  (mem_addr),
      .wdata_i (dm_req_wdata),
      .rdata_o (mem_rdata)
   );

   // Transaction FSM; reset drops any pending response and restores IF as
   // the last grant so the data port wins the first tie.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= GNT_IF;
         last_grant_q <= GNT_IF;
         addr_q       <= '0;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         rsp_valid_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_d) begin
                  state_q      <= ST_ACCESS;
                  grant_q      <= gnt_d;
                  last_grant_q <= gnt_d;
                  addr_q       <= sel_idx_d;
                  we_q         <= sel_we_d;
                  err_q        <= sel_err_d;
               end
            end
            ST_ACCESS: begin
               state_q     <= ST_RESP;
               rsp_valid_q <= 1'b1;
            end
            ST_RESP: begin
               if (rsp_take_d) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Stores and range errors answer with zero data; loads return the word
   // registered during ACCESS, which holds while the array is idle in RESP.
   always_comb begin
      rsp_data_d = (we_q || err_q) ? '0 : mem_rdata;
   end

   assign if_rsp_valid = rsp_valid_q && (grant_q == GNT_IF);
   assign dm_rsp_valid = rsp_valid_q && (grant_q == GNT_DM);
   assign if_rsp_data  = if_rsp_valid ? rsp_data_d : '0;
   assign dm_rsp_data  = dm_rsp_valid ? rsp_data_d : '0;
`ifdef MEM_RANGE_CHECK_EN
   assign rsp_err      = rsp_valid_q && err_q;
`else
   assign rsp_err      = 1'b0;
`endif
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Bench for mips32_mem_responder: directed scenarios followed by randomized
// traffic on both ports; a negedge monitor checks every response against a
// word-array model of the storage. Honours MEM_RANGE_CHECK_EN like the RTL.
`timescale 1ns/1ps
module tb_mips32_mem_responder;
   import mips32_pkg::*;

   localparam int DEPTH = 1024;

   // ---------------- clock / reset / DUT ----------------
   logic        clk1 = 1'b0;
   logic        rst  = 1'b1;
   logic        if_req_valid = 1'b0;
   logic        if_req_ready;
   logic [31:0] if_req_addr = '0;
   logic        if_rsp_valid;
   logic        if_rsp_ready = 1'b1;
   logic [31:0] if_rsp_data;
   logic        dm_req_valid = 1'b0;
   logic        dm_req_ready;
   logic        dm_req_we = 1'b0;
   logic [31:0] dm_req_addr = '0;
   logic [31:0] dm_req_wdata = '0;
   logic        dm_rsp_valid;
   logic        dm_rsp_ready = 1'b1;
   logic [31:0] dm_rsp_data;
   logic        rsp_err;
   state_e      dbg_state;

   always #5 clk1 = ~clk1;

   mips32_mem_responder #(.DEPTH(DEPTH)) dut (
      .clk1         (clk1),
      .rst          (rst),
      .if_req_valid (if_req_valid),
      .if_req_ready (if_req_ready),
      .if_req_addr  (if_req_addr),
      .if_rsp_valid (if_rsp_valid),
      .if_rsp_ready (if_rsp_ready),
      .if_rsp_data  (if_rsp_data),
      .dm_req_valid (dm_req_valid),
      .dm_req_ready (dm_req_ready),
      .dm_req_we    (dm_req_we),
      .dm_req_addr  (dm_req_addr),
      .dm_req_wdata (dm_req_wdata),
      .dm_rsp_valid (dm_rsp_valid),
      .dm_rsp_ready (dm_rsp_ready),
      .dm_rsp_data  (dm_rsp_data),
      .rsp_err      (rsp_err),
      .dbg_state_o  (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   typedef struct {
      bit          is_dm;
      logic [31:0] data;
      bit          err;
      int          acc_cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_mem [DEPTH];
   bit          last_was_dm = 1'b0;
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          rdy_mode = 0;        // 0: always ready, 1: random, 2: held low
   int          if_acc_cnt = 0;
   int          dm_acc_cnt = 0;
   bit          grant_log[$];
   int          acc_cyc_log[$];

   always @(posedge clk1) cyc <= cyc + 1;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // ---------------- monitor ----------------
   bit          m_got_dm, m_want_dm, m_rsp_seen;
   bit          prev_if_hold, prev_dm_hold;
   logic [31:0] prev_if_data, prev_dm_data;
   logic [31:0] m_addr;
   exp_t        m_e;

   always @(negedge clk1) begin
      if (rst) begin
         exp_q.delete();
         last_was_dm  = 1'b0;
         m_rsp_seen   = 1'b0;
         prev_if_hold = 1'b0;
         prev_dm_hold = 1'b0;
      end else begin
         // a stalled response must keep valid and data
         if (prev_if_hold) begin
            check("if_hold_valid", if_rsp_valid, 1);
            check("if_hold_data", if_rsp_data, prev_if_data);
         end
         if (prev_dm_hold) begin
            check("dm_hold_valid", dm_rsp_valid, 1);
            check("dm_hold_data", dm_rsp_data, prev_dm_data);
         end
         if (if_rsp_valid || dm_rsp_valid) begin
            check("req_ready_during_rsp", {if_req_ready, dm_req_ready}, 0);
            check("rsp_on_both_ports", if_rsp_valid & dm_rsp_valid, 0);
         end
         if (if_req_ready || dm_req_ready)
            check("ready_onehot", if_req_ready & dm_req_ready, 0);

         // acceptance: arbitration rule, then apply request to the model
         if ((if_req_valid && if_req_ready) || (dm_req_valid && dm_req_ready)) begin
            m_got_dm  = dm_req_valid && dm_req_ready;
            m_want_dm = dm_req_valid && !(if_req_valid && last_was_dm);
            check("grant_port", m_got_dm, m_want_dm);
            m_addr    = m_got_dm ? dm_req_addr : if_req_addr;
`ifdef MEM_RANGE_CHECK_EN
            m_e.err   = (m_addr >= DEPTH);
`else
            m_e.err   = 1'b0;
`endif
            m_e.is_dm   = m_got_dm;
            m_e.acc_cyc = cyc;
            if (m_got_dm && dm_req_we) begin
               if (!m_e.err) model_mem[m_addr % DEPTH] = dm_req_wdata;
               m_e.data = '0;
            end else begin
               m_e.data = m_e.err ? 32'h0 : model_mem[m_addr % DEPTH];
            end
            exp_q.push_back(m_e);
            last_was_dm = m_got_dm;
            grant_log.push_back(m_got_dm);
            acc_cyc_log.push_back(cyc);
            if (m_got_dm) dm_acc_cnt++; else if_acc_cnt++;
         end

         // responses
         if (if_rsp_valid || dm_rsp_valid) begin
            if (!m_rsp_seen) begin
               m_rsp_seen = 1'b1;
               if (exp_q.size() > 0)
                  check("rsp_latency", cyc - exp_q[0].acc_cyc, 2);
            end
            if ((if_rsp_valid && if_rsp_ready) || (dm_rsp_valid && dm_rsp_ready)) begin
               if (exp_q.size() == 0) begin
                  check("rsp_without_request", exp_q.size(), 1);
               end else begin
                  m_e = exp_q.pop_front();
                  check("rsp_port_dm", dm_rsp_valid, m_e.is_dm);
                  check("rsp_data", m_e.is_dm ? dm_rsp_data : if_rsp_data, m_e.data);
                  check("rsp_err", rsp_err, m_e.err);
               end
               m_rsp_seen = 1'b0;
            end
         end
         prev_if_hold = if_rsp_valid && !if_rsp_ready;
         prev_if_data = if_rsp_data;
         prev_dm_hold = dm_rsp_valid && !dm_rsp_ready;
         prev_dm_data = dm_rsp_data;
      end
   end

   // ---------------- response-ready driver ----------------
   initial begin
      forever begin
         @(posedge clk1); #1;
         case (rdy_mode)
            0: begin if_rsp_ready = 1'b1; dm_rsp_ready = 1'b1; end
            1: begin
               if_rsp_ready = ($urandom_range(0, 3) != 0);
               dm_rsp_ready = ($urandom_range(0, 3) != 0);
            end
            default: begin if_rsp_ready = 1'b0; dm_rsp_ready = 1'b0; end
         endcase
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_acc(input bit is_dm);
      int s;
      bit done;
      s    = is_dm ? dm_acc_cnt : if_acc_cnt;
      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(posedge clk1); #1;
         if ((is_dm ? dm_acc_cnt : if_acc_cnt) != s) done = 1'b1;
      end
      check(is_dm ? "dm_accept" : "if_accept", done, 1);
   endtask

   task automatic issue(input bit is_dm, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata);
      if (is_dm) begin
         dm_req_valid = 1'b1; dm_req_we = we; dm_req_addr = addr; dm_req_wdata = wdata;
      end else begin
         if_req_valid = 1'b1; if_req_addr = addr;
      end
      wait_acc(is_dm);
      if (is_dm) dm_req_valid = 1'b0; else if_req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 80 && exp_q.size() > 0; k++) begin
         @(posedge clk1); #1;
      end
      check("drain", exp_q.size(), 0);
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_if_req_ready"}, if_req_ready, 0);
      check({tag, "_dm_req_ready"}, dm_req_ready, 0);
      check({tag, "_if_rsp_valid"}, if_rsp_valid, 0);
      check({tag, "_dm_rsp_valid"}, dm_rsp_valid, 0);
      check({tag, "_if_rsp_data"}, if_rsp_data, 0);
      check({tag, "_dm_rsp_data"}, dm_rsp_data, 0);
      check({tag, "_rsp_err"}, rsp_err, 0);
      check({tag, "_state"}, dbg_state, ST_IDLE);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk1);
      check_all_zero("reset");
      if_req_valid = 1'b0;
      dm_req_valid = 1'b0;
      @(posedge clk1); #1;
      rst = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 6)      return 32'($urandom_range(0, 15));
      else if (r < 8) return 32'($urandom_range(0, DEPTH - 1));
      else if (r < 9) return 32'($urandom_range(DEPTH, DEPTH + 15));
      else            return $urandom;
   endfunction

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, miscompares so far %0d", miscompares);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   int if_s, dm_s;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         model_mem[i] = $urandom;
         dut.u_mem.mem[i] = model_mem[i];
      end
      model_mem[5] = 32'h2821_0005;
      dut.u_mem.mem[5] = 32'h2821_0005;

      // reset with requests pending: nothing may be granted
      if_req_valid = 1'b1;
      dm_req_valid = 1'b1;
      repeat (2) @(posedge clk1);
      #1;
      do_reset();

      // instruction fetch of a preloaded word
      issue(0, 0, 32'd5, 32'h0);
      wait_drain();

      // store then load of the same word
      issue(1, 1, 32'd120, 32'hDEAD_BEEF);
      wait_drain();
      issue(1, 0, 32'd120, 32'h0);
      wait_drain();

      // three simultaneous requests after reset: DM, IF, DM
      do_reset();
      grant_log.delete();
      acc_cyc_log.delete();
      if_req_valid = 1'b1; if_req_addr = 32'd7;
      dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 32'd8;
      wait_acc(1);
      dm_req_addr = 32'd9;
      wait_acc(0);
      if_req_addr = 32'd10;
      wait_acc(1);
      dm_req_valid = 1'b0;
      wait_acc(0);
      if_req_valid = 1'b0;
      wait_drain();
      check("grant_log_size", grant_log.size(), 4);
      if (grant_log.size() >= 4) begin
         check("grant_0_dm", grant_log[0], 1);
         check("grant_1_dm", grant_log[1], 0);
         check("grant_2_dm", grant_log[2], 1);
         check("b2b_spacing_0", acc_cyc_log[1] - acc_cyc_log[0], 3);
         check("b2b_spacing_1", acc_cyc_log[2] - acc_cyc_log[1], 3);
      end

      // stalled data response with a competing fetch waiting
      rdy_mode = 2;
      issue(1, 0, 32'd120, 32'h0);
      if_req_valid = 1'b1; if_req_addr = 32'd11;
      repeat (7) @(posedge clk1);
      #1;
      check("dm_rsp_stalled_valid", dm_rsp_valid, 1);
      check("if_not_accepted_during_stall", if_req_ready, 0);
      rdy_mode = 0;
      wait_acc(0);
      if_req_valid = 1'b0;
      wait_drain();

      // reset while the store is in ACCESS; the store must persist
      issue(1, 1, 32'd300, 32'hCAFE_F00D);
      check("state_access", dbg_state, ST_ACCESS);
      do_reset();
      issue(1, 0, 32'd300, 32'h0);
      wait_drain();

      // address beyond the array
      issue(0, 0, 32'd1030, 32'h0);
      wait_drain();
      issue(1, 1, 32'd1030, 32'h1234_5678);
      wait_drain();
      issue(1, 0, 32'd6, 32'h0);
      wait_drain();

      // randomized traffic on both ports with random response back-pressure
      rdy_mode = 1;
      if_s = if_acc_cnt;
      dm_s = dm_acc_cnt;
      for (int n = 0; n < 600; n++) begin
         @(posedge clk1); #1;
         if (if_req_valid && if_acc_cnt != if_s) if_req_valid = 1'b0;
         if (dm_req_valid && dm_acc_cnt != dm_s) dm_req_valid = 1'b0;
         if (!if_req_valid && $urandom_range(0, 1) == 1) begin
            if_req_valid = 1'b1;
            if_req_addr  = rand_addr();
            if_s         = if_acc_cnt;
         end
         if (!dm_req_valid && $urandom_range(0, 1) == 1) begin
            dm_req_valid = 1'b1;
            dm_req_we    = $urandom_range(0, 1);
            dm_req_addr  = rand_addr();
            dm_req_wdata = $urandom;
            dm_s         = dm_acc_cnt;
         end
      end
      // let any request already granted finish before dropping valids
      for (int k = 0; k < 20 && dbg_state != ST_IDLE; k++) begin
         @(posedge clk1); #1;
      end
      if_req_valid = 1'b0;
      dm_req_valid = 1'b0;
      rdy_mode = 0;
      wait_drain();
      repeat (3) @(posedge clk1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
